operate_uart_tx: RTL

Serialises the debounced operate byte from the button operate machine onto the UART line to the host. The block watches the byte each `uart_clk` cycle and sends one 8N1 frame whenever the value changes. It keeps only the newest value that arrives while a frame is in flight, and can re-send the last value periodically as a heartbeat. It is the stage directly downstream of the button decoder and drives the board's TX pin.

---
 rtl/operate_uart_tx.sv | 100 ++++++++++
 1 files changed

// File: rtl/operate_uart_tx.sv
// operate_uart_tx: sends the normalised operate byte as an 8N1 frame on every change, latest-wins pending, optional heartbeat.
// Define OPERATE_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module operate_uart_tx #(
  parameter int         CLKS_PER_BIT  = 16,
  parameter int         REPEAT_CYCLES = 0,
  parameter logic [7:0] IDLE_CODE     = 8'b0000_0010
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int              CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [23:0]     HB_LAST = 24'(REPEAT_CYCLES - 1);
`ifdef OPERATE_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, norm, last_sent, pend_val, load_val;
  logic [23:0] idle_cnt;
  logic pend_vld, bit_end, change, hb_fire, take, load, tx_n, unused_msb;
  assign norm       = {1'b0, data_in[6:0]};
  assign unused_msb = data_in[7];
  assign bit_end    = cnt == LAST;
  assign change     = norm != last_sent && (!pend_vld || norm != pend_val);
  // Heartbeat launches straight from IDLE so the re-send lines up with the idle count.
  assign hb_fire    = REPEAT_CYCLES != 0 && state == IDLE && !pend_vld && !change && idle_cnt == HB_LAST;
  assign take       = pend_vld && (state == IDLE || (state == STOP && bit_end));
  assign load       = take || hb_fire;
  assign load_val   = hb_fire ? last_sent : pend_val;
`ifdef OPERATE_TX_PARITY_EN
  logic par;
  always_ff @(posedge uart_clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (load) par <= ^load_val;
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par : 1'b1;
`else
  assign tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + CW'(1);
    idx_n   = idx;
    sh_n    = load ? load_val : sh;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = load ? START : IDLE;
      end
      START: state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        sh_n    = sh >> 1;
        idx_n   = idx + 3'd1;
        state_n = idx == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef OPERATE_TX_PARITY_EN
      PARITY: state_n = bit_end ? STOP : PARITY;
`endif
      STOP: state_n = !bit_end ? STOP : load ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge uart_clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      last_sent  <= IDLE_CODE;
      pend_val   <= '0;
      pend_vld   <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      tx         <= tx_n;
      busy       <= state_n != IDLE;
      frame_done <= state_n == STOP && cnt_n == LAST;
      if (change) begin
        pend_val  <= norm;
        pend_vld  <= 1'b1;
        last_sent <= norm;
      end else if (take) pend_vld <= 1'b0;
      idle_cnt <= load ? '0 : (state == IDLE && !pend_vld) ? idle_cnt + 24'd1 : idle_cnt;
    end
endmodule
